// File: rtl/writeback_stage.sv
// writeback_stage
// ---------------------------------------------------------------------------
// Two-entry in-order write buffer between the execute stage and the register
// file. Each entry carries up to two register writes. The head entry drives
// the register file write ports while wb_hold is low. Decode read data can be
// corrected for writes that are still buffered.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   : fwd_rdK_out forwards pending buffered writes.
//   undefined : fwd_rdK_out = reg_rdK_out, and no address comparators exist.
//
// Handshake: a request is taken on a rising clock edge when ex_valid and
// ex_ready are both high. ex_ready depends only on the registered occupancy.
// A request with both write enables low still takes an entry.
//
// Ports
//   clock, reset                    rising-edge clock, async active-high reset
//   ex_valid / ex_ready             execute-stage request handshake
//   ex_wr{1,2}_addr/_data/_en       request payload, two write ports
//   wb_hold                         stalls draining to the register file
//   reg_wr{1,2}, _data, _enable     register file write ports (head entry)
//   reg_rd{1,2,3}, reg_rd{1,2,3}_out  decode read addresses / raw read data
//   fwd_rd{1,2,3}_out               read data corrected for pending writes
//   wb_count                        occupied entries (0..2)
//   wb_retired                      drained entries with any enable set
// ---------------------------------------------------------------------------
module writeback_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [5:0]  ex_wr1_addr,
  input  logic [5:0]  ex_wr2_addr,
  input  logic [15:0] ex_wr1_data,
  input  logic [15:0] ex_wr2_data,
  input  logic        ex_wr1_en,
  input  logic        ex_wr2_en,
  input  logic        wb_hold,
  output logic [5:0]  reg_wr1,
  output logic [5:0]  reg_wr2,
  output logic [15:0] reg_wr1_data,
  output logic [15:0] reg_wr2_data,
  output logic        reg_wr1_enable,
  output logic        reg_wr2_enable,
  input  logic [5:0]  reg_rd1,
  input  logic [5:0]  reg_rd2,
  input  logic [5:0]  reg_rd3,
  input  logic [15:0] reg_rd1_out,
  input  logic [15:0] reg_rd2_out,
  input  logic [15:0] reg_rd3_out,
  output logic [15:0] fwd_rd1_out,
  output logic [15:0] fwd_rd2_out,
  output logic [15:0] fwd_rd3_out,
  output logic [1:0]  wb_count,
  output logic [15:0] wb_retired
);

  // Entry storage, indexed by slot (0/1).
  logic [5:0]  a1_q [2];
  logic [5:0]  a2_q [2];
  logic [15:0] d1_q [2];
  logic [15:0] d2_q [2];
  logic [1:0]  e1_q;
  logic [1:0]  e2_q;

  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [15:0] retired;

  logic push;
  logic drain;
  logic head_any_en;

  assign ex_ready    = (count != 2'd2);
  assign push        = ex_valid && ex_ready;
  assign drain       = (count != 2'd0) && !wb_hold;
  assign head_any_en = e1_q[rd_ptr] || e2_q[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        a1_q[i] <= 6'd0;
        a2_q[i] <= 6'd0;
        d1_q[i] <= 16'd0;
        d2_q[i] <= 16'd0;
      end
      e1_q    <= 2'b00;
      e2_q    <= 2'b00;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
      retired <= 16'd0;
    end else begin
      if (push) begin
        a1_q[wr_ptr] <= ex_wr1_addr;
        a2_q[wr_ptr] <= ex_wr2_addr;
        d1_q[wr_ptr] <= ex_wr1_data;
        d2_q[wr_ptr] <= ex_wr2_data;
        e1_q[wr_ptr] <= ex_wr1_en;
        e2_q[wr_ptr] <= ex_wr2_en;
        wr_ptr       <= ~wr_ptr;
      end
      if (drain) begin
        rd_ptr <= ~rd_ptr;
        if (head_any_en) begin
          retired <= retired + 16'd1;
        end
      end
      count <= count + {1'b0, push} - {1'b0, drain};
    end
  end

  assign wb_count   = count;
  assign wb_retired = retired;

  // Head entry drives the register file directly.
  assign reg_wr1      = a1_q[rd_ptr];
  assign reg_wr2      = a2_q[rd_ptr];
  assign reg_wr1_data = d1_q[rd_ptr];
  assign reg_wr2_data = d2_q[rd_ptr];

  // Same-address double write: port 2 is the later write in program order,
  // so port 1 is suppressed rather than relying on register file ordering.
  assign reg_wr1_enable = drain && e1_q[rd_ptr] &&
                          !(e2_q[rd_ptr] && (a1_q[rd_ptr] == a2_q[rd_ptr]));
  assign reg_wr2_enable = drain && e2_q[rd_ptr];

`ifdef WB_BYPASS_EN
  logic [5:0]  rd_addr [3];
  logic [15:0] rd_raw  [3];
  logic [15:0] rd_fwd  [3];
  logic        new_idx;
  logic        new_valid;
  logic        old_valid;

  // With one entry it is both newest and oldest; with two the newest sits
  // in the slot after the head.
  assign new_valid = (count != 2'd0);
  assign old_valid = (count == 2'd2);
  assign new_idx   = (count == 2'd2) ? ~rd_ptr : rd_ptr;

  assign rd_addr[0] = reg_rd1;
  assign rd_addr[1] = reg_rd2;
  assign rd_addr[2] = reg_rd3;
  assign rd_raw[0]  = reg_rd1_out;
  assign rd_raw[1]  = reg_rd2_out;
  assign rd_raw[2]  = reg_rd3_out;

  // Apply matches from lowest to highest priority; later hits override.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rd_fwd[k] = rd_raw[k];
      if (old_valid && e1_q[rd_ptr] && (a1_q[rd_ptr] == rd_addr[k]))
        rd_fwd[k] = d1_q[rd_ptr];
      if (old_valid && e2_q[rd_ptr] && (a2_q[rd_ptr] == rd_addr[k]))
        rd_fwd[k] = d2_q[rd_ptr];
      if (new_valid && e1_q[new_idx] && (a1_q[new_idx] == rd_addr[k]))
        rd_fwd[k] = d1_q[new_idx];
      if (new_valid && e2_q[new_idx] && (a2_q[new_idx] == rd_addr[k]))
        rd_fwd[k] = d2_q[new_idx];
    end
  end

  assign fwd_rd1_out = rd_fwd[0];
  assign fwd_rd2_out = rd_fwd[1];
  assign fwd_rd3_out = rd_fwd[2];
`else
  // Read addresses have no consumer without forwarding.
  logic unused_rd_addr;
  assign unused_rd_addr = ^{reg_rd1, reg_rd2, reg_rd3};

  assign fwd_rd1_out = reg_rd1_out;
  assign fwd_rd2_out = reg_rd2_out;
  assign fwd_rd3_out = reg_rd3_out;
`endif

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have no parameters; storage is fixed at 2 entries, 6-bit register address, 16-bit data.
REQ-002 SHALL have port `clock  in  1`: rising-edge clock.
REQ-003 SHALL have port `reset  in  1`: asynchronous, active-high reset.
REQ-004 SHALL have port `ex_valid  in  1`: execute stage presents a write request.
REQ-005 SHALL have port `ex_ready  out  1`: stage can accept a request this cycle.
REQ-006 SHALL have ports `ex_wr1_addr, ex_wr2_addr  in  6`: destination registers.
REQ-007 SHALL have ports `ex_wr1_data, ex_wr2_data  in  16`: result data.
REQ-008 SHALL have ports `ex_wr1_en, ex_wr2_en  in  1`: per-port write request.
REQ-009 SHALL have port `wb_hold  in  1`: blocks draining to the register file.
REQ-010 SHALL have ports `reg_wr1, reg_wr2  out  6`, `reg_wr1_data, reg_wr2_data  out  16`, `reg_wr1_enable, reg_wr2_enable  out  1`: register file write ports.
REQ-011 SHALL have ports `reg_rd1, reg_rd2, reg_rd3  in  6`: read addresses issued by decode.
REQ-012 SHALL have ports `reg_rd1_out, reg_rd2_out, reg_rd3_out  in  16`: raw register file read data.
REQ-013 SHALL have ports `fwd_rd1_out, fwd_rd2_out, fwd_rd3_out  out  16`: read data corrected for pending writes.
REQ-014 SHALL have port `wb_count  out  2`: number of occupied entries (0..2).
REQ-015 SHALL have port `wb_retired  out  16`: count of drained entries with at least one enable set.

Function
REQ-016 SHALL hold a 2-entry in-order FIFO; each entry stores {wr1_addr, wr1_data, wr1_en, wr2_addr, wr2_data, wr2_en}.
REQ-017 SHALL drive ex_ready = (wb_count < 2); ex_ready SHALL depend only on registered count, not on same-cycle drain.
REQ-018 SHALL push on a rising edge when ex_valid && ex_ready; requests with both enables 0 SHALL still occupy an entry (bubble).
REQ-019 SHALL drain the head entry on a rising edge when wb_count > 0 && !wb_hold.
REQ-020 SHALL drive reg_wr*/reg_wr*_data combinationally from the head entry; reg_wrN_enable = headN_en && wb_count > 0 && !wb_hold.
REQ-021 SHALL give latency 1: a request pushed at edge N with empty FIFO and wb_hold=0 is written by the register file at edge N+1.
REQ-022 SHALL, when head wr1_en and wr2_en are both 1 with equal addresses, force reg_wr1_enable to 0 so that port 2 wins.
REQ-023 SHALL allow simultaneous push and drain when wb_count=1, leaving wb_count=1.
REQ-024 SHALL leave the FIFO unchanged while wb_hold=1, and SHALL accept pushes until full.
REQ-025 SHALL increment wb_retired on each drain with any enable set, wrapping 0xFFFF -> 0x0000.
REQ-026 SHALL compute fwd_rdK_out combinationally with priority: newest entry port 2 > newest port 1 > oldest port 2 > oldest port 1 > reg_rdK_out.
REQ-027 SHALL include in that match only occupied entries with the relevant enable set.

Reset
REQ-028 SHALL clear on reset: FIFO (wb_count=0), wb_retired=0x0000, reg_wr1_enable=reg_wr2_enable=0, ex_ready=1.
REQ-029 SHALL, when reset asserts mid-operation, discard pending entries with no register write issued, and SHALL ignore a push coinciding with reset.
REQ-030 SHALL reset stored address/data fields to 0.

Configuration
REQ-031 SHALL, with WB_BYPASS_EN defined, implement the forwarding of REQ-026/027.
REQ-032 SHALL, without WB_BYPASS_EN, drive fwd_rdK_out = reg_rdK_out with no comparators synthesised; all other behaviour is identical.

Verification
REQ-033 Single write: push wr1=(5,0x1234) with FIFO empty -> reg_wr1=5, data=0x1234, enable=1 in the next cycle; wb_retired=1.
REQ-034 Port collision: push wr1=(7,0xAAAA) and wr2=(7,0x5555) -> reg_wr1_enable=0, reg_wr2_enable=1, register 7 = 0x5555.
REQ-035 Hold/full: wb_hold=1, push 3 back-to-back requests -> 2 accepted, ex_ready=0, wb_count=2; release hold -> drained in order over 2 cycles.
REQ-036 Bypass (WB_BYPASS_EN): hold with entries wr1=(3,0x0011) then wr2=(3,0x0022), reg_rd1=3 -> fwd_rd1_out=0x0022; undefined macro -> raw value.
REQ-037 Reset mid-op: 2 entries pending, assert reset -> wb_count=0, no enables asserted, wb_retired=0.
REQ-038 Wrap: preload via 65536 enabled drains -> wb_retired returns to 0x0000.
